// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the block-RAM port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W = 16;
  localparam int unsigned DEF_DATA_W = 16;

  // Encoding is fixed so state values match the original controller.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CPU_ADDR = 3'd1,
    CPU_DATA = 3'd2,
    IO_BURST = 3'd3,
    IO_DRAIN = 3'd4
  } arb_state_e;

  typedef enum logic {
    GRANT_CPU = 1'b0,
    GRANT_IO  = 1'b1
  } grant_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and RAM signals of the arbiter.
// The slave modport is the arbiter side; master is the CPU/IO/RAM side.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  logic              io_req;
  logic [ADDR_W-1:0] io_addr;
  logic              io_ack;
  logic [DATA_W-1:0] io_rdata;
  logic              io_done;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, io_req, io_addr, mem_rdata,
    output cpu_ack, cpu_rdata, io_ack, io_rdata, io_done, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, io_req, io_addr, mem_rdata,
    input  cpu_ack, cpu_rdata, io_ack, io_rdata, io_done, mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/mem_port_burst_ctr.sv
// IO burst beat counter with base+beat address generation.
// Address wraps modulo 2^ADDR_W past the top of memory.
module mem_port_burst_ctr #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              advance_i,
  input  logic [ADDR_W-1:0] base_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              first_o,
  output logic              last_o
);

  localparam int unsigned BEAT_W = $clog2(BURST_LEN);

  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [ADDR_W-1:0] base_q, base_d;

  // Start a new burst at beat 0 or step to the next beat.
  always_comb begin
    beat_d = beat_q;
    base_d = base_q;
    if (load_i) begin
      beat_d = '0;
      base_d = base_i;
    end else if (advance_i) begin
      beat_d = beat_q + BEAT_W'(1);
    end
  end

  // Counter and base registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beat_q <= '0;
      base_q <= '0;
    end else begin
      beat_q <= beat_d;
      base_q <= base_d;
    end
  end

  assign addr_o  = base_q + ADDR_W'(beat_q);
  assign first_o = (beat_q == '0);
  assign last_o  = (beat_q == BEAT_W'(BURST_LEN - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port block-RAM arbiter between the CPU load/store path and the
// IO refresh burst reader. Requests are only sampled in IDLE; no preemption.
// Optional macro MEM_PORT_ARBITER_ROUND_ROBIN_EN: ties alternate between
// requesters instead of always going to the CPU.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic                clock,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus
);

  arb_state_e state_q, state_d;

  logic              grant_cpu;
  logic              grant_io;
  logic              cpu_wins_tie;

  logic              cpu_we_q,    cpu_we_d;
  logic [ADDR_W-1:0] cpu_addr_q,  cpu_addr_d;
  logic [DATA_W-1:0] cpu_wdata_q, cpu_wdata_d;

  logic [ADDR_W-1:0] burst_addr;
  logic              burst_first;
  logic              burst_last;
  logic              burst_advance;

`ifdef MEM_PORT_ARBITER_ROUND_ROBIN_EN
  grant_e last_grant_q, last_grant_d;

  // Remember who was granted last so the other side wins the next tie.
  always_comb begin
    last_grant_d = last_grant_q;
    if (grant_cpu) begin
      last_grant_d = GRANT_CPU;
    end else if (grant_io) begin
      last_grant_d = GRANT_IO;
    end
  end

  // Last-grant register; resets to IO so the CPU takes the first tie.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant_q <= GRANT_IO;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  assign cpu_wins_tie = (last_grant_q == GRANT_IO);
`else
  assign cpu_wins_tie = 1'b1;
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Arbitration in IDLE and next-state sequencing.
  always_comb begin
    state_d       = state_q;
    grant_cpu     = 1'b0;
    grant_io      = 1'b0;
    burst_advance = 1'b0;
    case (state_q)
      IDLE: begin
        grant_cpu = bus.cpu_req && (!bus.io_req || cpu_wins_tie);
        grant_io  = bus.io_req && !grant_cpu;
        if (grant_cpu) begin
          state_d = CPU_ADDR;
        end else if (grant_io) begin
          state_d = IO_BURST;
        end
      end
      CPU_ADDR: state_d = CPU_DATA;
      CPU_DATA: state_d = IDLE;
      IO_BURST: begin
        if (burst_last) begin
          state_d = IO_DRAIN;
        end else begin
          burst_advance = 1'b1;
        end
      end
      IO_DRAIN: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Capture the CPU request at grant time.
  always_comb begin
    cpu_we_d    = cpu_we_q;
    cpu_addr_d  = cpu_addr_q;
    cpu_wdata_d = cpu_wdata_q;
    if (grant_cpu) begin
      cpu_we_d    = bus.cpu_we;
      cpu_addr_d  = bus.cpu_addr;
      cpu_wdata_d = bus.cpu_wdata;
    end
  end

  // Latched CPU request registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      cpu_we_q    <= 1'b0;
      cpu_addr_q  <= '0;
      cpu_wdata_q <= '0;
    end else begin
      cpu_we_q    <= cpu_we_d;
      cpu_addr_q  <= cpu_addr_d;
      cpu_wdata_q <= cpu_wdata_d;
    end
  end

  mem_port_burst_ctr #(
    .ADDR_W    (ADDR_W),
    .BURST_LEN (BURST_LEN)
  ) u_burst_ctr (
    .clk_i     (clock),
    .rst_i     (reset),
    .load_i    (grant_io),
    .advance_i (burst_advance),
    .base_i    (bus.io_addr),
    .addr_o    (burst_addr),
    .first_o   (burst_first),
    .last_o    (burst_last)
  );

  // Drive RAM controls and requester returns from the current state.
  always_comb begin
    bus.cpu_ack   = 1'b0;
    bus.cpu_rdata = '0;
    bus.io_ack    = 1'b0;
    bus.io_rdata  = '0;
    bus.io_done   = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    case (state_q)
      CPU_ADDR: begin
        bus.mem_addr  = cpu_addr_q;
        bus.mem_we    = cpu_we_q;
        bus.mem_wdata = cpu_wdata_q;
      end
      CPU_DATA: begin
        bus.cpu_ack   = 1'b1;
        bus.cpu_rdata = bus.mem_rdata;
      end
      IO_BURST: begin
        bus.mem_addr = burst_addr;
        // Beat 0 only issues an address; its word returns on the next beat.
        if (!burst_first) begin
          bus.io_ack   = 1'b1;
          bus.io_rdata = bus.mem_rdata;
        end
      end
      IO_DRAIN: begin
        bus.io_ack   = 1'b1;
        bus.io_done  = 1'b1;
        bus.io_rdata = bus.mem_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a synchronous RAM model.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned BL = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .BURST_LEN (BL)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Synchronous single-port RAM, read data one cycle after address.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clock) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  int unsigned err_cnt = 0;
  int unsigned chk_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_cpu_ack"},   bus.cpu_ack,   0);
    check_eq({tag, "_cpu_rdata"}, bus.cpu_rdata, 0);
    check_eq({tag, "_io_ack"},    bus.io_ack,    0);
    check_eq({tag, "_io_rdata"},  bus.io_rdata,  0);
    check_eq({tag, "_io_done"},   bus.io_done,   0);
    check_eq({tag, "_mem_addr"},  bus.mem_addr,  0);
    check_eq({tag, "_mem_we"},    bus.mem_we,    0);
    check_eq({tag, "_mem_wdata"}, bus.mem_wdata, 0);
  endtask

  // One CPU access starting at the next (IDLE) cycle T; ack expected at T+2.
  task automatic cpu_access(input string tag, input logic we, input logic [15:0] addr,
                            input logic [15:0] wdata, input logic [15:0] exp_rdata);
    @(negedge clock);
    check_eq({tag, "_t0_ack"}, bus.cpu_ack, 0);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    @(negedge clock);
    check_eq({tag, "_t1_ack"},  bus.cpu_ack,  0);
    check_eq({tag, "_t1_addr"}, bus.mem_addr, addr);
    check_eq({tag, "_t1_we"},   bus.mem_we,   we);
    if (we) check_eq({tag, "_t1_wdata"}, bus.mem_wdata, wdata);
    @(negedge clock);
    check_eq({tag, "_t2_ack"}, bus.cpu_ack, 1);
    check_eq({tag, "_t2_we"},  bus.mem_we,  0);
    check_eq({tag, "_t2_io"},  bus.io_ack,  0);
    if (!we) check_eq({tag, "_t2_rdata"}, bus.cpu_rdata, exp_rdata);
    bus.cpu_req = 1'b0;
  endtask

  // One full IO burst starting at the next (IDLE) cycle.
  task automatic io_burst(input string tag, input logic [15:0] base,
                          input logic [15:0] w0, input logic [15:0] w1,
                          input logic [15:0] w2, input logic [15:0] w3);
    logic [15:0] w [4];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    @(negedge clock);
    check_eq({tag, "_idle_ack"}, bus.io_ack, 0);
    bus.io_req  = 1'b1;
    bus.io_addr = base;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check_eq($sformatf("%s_b%0d_addr", tag, k), bus.mem_addr, 16'(base + 16'(k)));
      check_eq($sformatf("%s_b%0d_we", tag, k),   bus.mem_we,   0);
      check_eq($sformatf("%s_b%0d_done", tag, k), bus.io_done,  0);
      check_eq($sformatf("%s_b%0d_ack", tag, k),  bus.io_ack,   (k != 0));
      check_eq($sformatf("%s_b%0d_data", tag, k), bus.io_rdata, (k != 0) ? w[k-1] : 16'h0);
    end
    @(negedge clock);
    check_eq({tag, "_drain_ack"},  bus.io_ack,   1);
    check_eq({tag, "_drain_done"}, bus.io_done,  1);
    check_eq({tag, "_drain_data"}, bus.io_rdata, w[3]);
    check_eq({tag, "_drain_we"},   bus.mem_we,   0);
    bus.io_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.io_req    = 1'b0;
    bus.io_addr   = '0;
    reset         = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check_quiet("reset");
    reset = 1'b0;

    // Store then load back through the CPU path.
    cpu_access("st10", 1'b1, 16'h0010, 16'hBEEF, 16'h0000);
    cpu_access("ld10", 1'b0, 16'h0010, 16'h0000, 16'hBEEF);

    // Preload burst regions.
    cpu_access("pl100", 1'b1, 16'h0100, 16'h0001, 16'h0);
    cpu_access("pl101", 1'b1, 16'h0101, 16'h0002, 16'h0);
    cpu_access("pl102", 1'b1, 16'h0102, 16'h0003, 16'h0);
    cpu_access("pl103", 1'b1, 16'h0103, 16'h0004, 16'h0);
    cpu_access("plfffe", 1'b1, 16'hFFFE, 16'h00A1, 16'h0);
    cpu_access("plffff", 1'b1, 16'hFFFF, 16'h00A2, 16'h0);
    cpu_access("pl0000", 1'b1, 16'h0000, 16'h00A3, 16'h0);
    cpu_access("pl0001", 1'b1, 16'h0001, 16'h00A4, 16'h0);

    io_burst("burst", 16'h0100, 16'h0001, 16'h0002, 16'h0003, 16'h0004);
    io_burst("wrap",  16'hFFFE, 16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4);

    // Two ties in a row; the last grant before this was IO.
    @(negedge clock);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 16'h0010;
    bus.io_req   = 1'b1;
    bus.io_addr  = 16'h0100;
    @(negedge clock);
    check_eq("tie1_addr", bus.mem_addr, 16'h0010);
    check_eq("tie1_ioack", bus.io_ack, 0);
    @(negedge clock);
    check_eq("tie1_cpuack", bus.cpu_ack, 1);
    check_eq("tie1_rdata", bus.cpu_rdata, 16'hBEEF);
    check_eq("tie1_ioack2", bus.io_ack, 0);
    @(negedge clock);
    check_eq("tie_idle_cpuack", bus.cpu_ack, 0);
    check_eq("tie_idle_addr", bus.mem_addr, 0);
    @(negedge clock);
    bus.cpu_req = 1'b0;
    bus.io_req  = 1'b0;
`ifdef MEM_PORT_ARBITER_ROUND_ROBIN_EN
    check_eq("tie2_io_addr", bus.mem_addr, 16'h0100);
    @(negedge clock);
    check_eq("tie2_io_ack", bus.io_ack, 1);
    check_eq("tie2_io_data", bus.io_rdata, 16'h0001);
    check_eq("tie2_cpu_ack", bus.cpu_ack, 0);
`else
    check_eq("tie2_cpu_addr", bus.mem_addr, 16'h0010);
    @(negedge clock);
    check_eq("tie2_cpu_ack", bus.cpu_ack, 1);
    check_eq("tie2_io_ack", bus.io_ack, 0);
`endif
    repeat (7) @(negedge clock);
    check_quiet("tie_settle");

    // CPU request arrives in the second burst cycle and waits for the drain.
    @(negedge clock);
    bus.io_req  = 1'b1;
    bus.io_addr = 16'h0100;
    @(negedge clock);
    check_eq("mid_b0_addr", bus.mem_addr, 16'h0100);
    @(negedge clock);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 16'h0010;
    check_eq("mid_b1_data", bus.io_rdata, 16'h0001);
    @(negedge clock);
    check_eq("mid_b2_addr", bus.mem_addr, 16'h0102);
    check_eq("mid_b2_data", bus.io_rdata, 16'h0002);
    check_eq("mid_b2_cpuack", bus.cpu_ack, 0);
    @(negedge clock);
    check_eq("mid_b3_addr", bus.mem_addr, 16'h0103);
    check_eq("mid_b3_data", bus.io_rdata, 16'h0003);
    @(negedge clock);
    check_eq("mid_drain_done", bus.io_done, 1);
    check_eq("mid_drain_data", bus.io_rdata, 16'h0004);
    check_eq("mid_drain_cpuack", bus.cpu_ack, 0);
    bus.io_req = 1'b0;
    @(negedge clock);
    check_eq("mid_idle_cpuack", bus.cpu_ack, 0);
    check_eq("mid_idle_ioack", bus.io_ack, 0);
    @(negedge clock);
    check_eq("mid_cpu_addr", bus.mem_addr, 16'h0010);
    check_eq("mid_cpu_ack1", bus.cpu_ack, 0);
    @(negedge clock);
    check_eq("mid_cpu_ack2", bus.cpu_ack, 1);
    check_eq("mid_cpu_rdata", bus.cpu_rdata, 16'hBEEF);
    bus.cpu_req = 1'b0;

    // Reset in the third burst cycle abandons the burst.
    @(negedge clock);
    bus.io_req  = 1'b1;
    bus.io_addr = 16'h0100;
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    check_eq("rst_b2_addr", bus.mem_addr, 16'h0102);
    reset      = 1'b1;
    bus.io_req = 1'b0;
    @(negedge clock);
    check_quiet("rst_mid");
    reset = 1'b0;
    @(negedge clock);
    check_quiet("rst_after");
    io_burst("restart", 16'h0100, 16'h0001, 16'h0002, 16'h0003, 16'h0004);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port synchronous block RAM between two requesters:
  - the CPU load/store path, driven by the multicycle control FSM;
  - the display/IO refresh reader, which fetches fixed-length bursts.
- Sequences RAM address, write-enable and read-data return for each requester.
- Sits between the CPU datapath, the IO reader and the RAM.

Parameters:
ADDR_W, 16, RAM address width
DATA_W, 16, RAM data width
BURST_LEN, 4, words per IO burst (2..256)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
cpu_req  in  1  CPU access request; held until cpu_ack
cpu_we  in  1  1 = store, 0 = load
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  store data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  DATA_W  load data, valid only while cpu_ack = 1
io_req  in  1  burst request; held until io_done
io_addr  in  ADDR_W  burst base address
io_ack  out  1  one pulse per returned word
io_rdata  out  DATA_W  burst word, valid while io_ack = 1
io_done  out  1  pulses together with the last io_ack of a burst
mem_addr  out  ADDR_W  RAM address
mem_we  out  1  RAM write enable
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, valid one cycle after its address

Behaviour:
- Reset: synchronous, active-high. On a reset edge:
  - state goes to IDLE; beat counter and latched request registers clear;
  - last_grant = IO;
  - all outputs read 0 from the following cycle.
- Reset mid-burst or mid-access abandons the transfer. No ack or done is issued for it.
- States: IDLE, CPU_ADDR, CPU_DATA, IO_BURST, IO_DRAIN.
- IDLE:
  - Requests are sampled only in IDLE.
  - Only cpu_req: latch cpu_addr, cpu_we, cpu_wdata; go to CPU_ADDR.
  - Only io_req: latch io_addr; beat counter = 0; go to IO_BURST.
  - Both: CPU wins (see Optional Feature).
  - Neither: stay in IDLE; mem_* = 0.
- CPU_ADDR: mem_addr = latched address; mem_we = latched we; mem_wdata = latched data. Go to CPU_DATA.
- CPU_DATA:
  - cpu_ack = 1; cpu_rdata = mem_rdata (don't-care on a store); mem_we = 0.
  - Go to IDLE.
- CPU latency: req first sampled in IDLE cycle T; address in T+1; ack in T+2.
- CPU req hold rule: requester drops cpu_req on the edge ending the ack cycle. A req still high in the next IDLE is treated as a new request.
- IO_BURST:
  - mem_addr = base + beat, modulo 2^ADDR_W (wraps past the top of memory); mem_we = 0.
  - From beat 1 on, io_ack = 1 and io_rdata = mem_rdata (the word for beat-1).
  - When beat = BURST_LEN-1, go to IO_DRAIN; otherwise beat increments.
- IO_DRAIN: io_ack = 1; io_done = 1; io_rdata = last word. Go to IDLE.
- Burst timing: BURST_LEN+1 cycles from IO_BURST entry to io_done; acks on consecutive cycles.
- No preemption: a CPU request arriving mid-burst waits. Worst-case CPU wait = BURST_LEN+1 cycles + 2-cycle access.
- While cpu_ack = 0, cpu_rdata = 0. While io_ack = 0, io_rdata = 0.
- cpu_ack and io_ack are never high in the same cycle.

Optional Feature:
- Macro: MEM_PORT_ARBITER_ROUND_ROBIN_EN.
- Defined:
  - last_grant register is updated at each grant;
  - on simultaneous requests in IDLE, the requester not granted last wins;
  - reset value last_grant = IO, so the CPU wins the first tie.
- Undefined:
  - fixed priority, CPU always wins ties;
  - last_grant is absent;
  - IO can starve under continuous CPU traffic. Accepted, because the CPU issues at most one access per 4-cycle instruction.

Decomposition:
- Package mem_port_arbiter_pkg:
  - state encoding localparams (IDLE = 0, CPU_ADDR = 1, CPU_DATA = 2, IO_BURST = 3, IO_DRAIN = 4, 3-bit);
  - GRANT_CPU / GRANT_IO constants;
  - default ADDR_W / DATA_W.
- One sub-module: mem_port_burst_ctr.
  - Beat counter plus base+beat address adder.
  - Outputs: last-beat flag and wrapped address.

Test Plan:
- After reset, cpu_req=1, we=1, addr=0x0010, wdata=0xBEEF, then load from 0x0010 -> second cpu_ack carries cpu_rdata=0xBEEF; each ack exactly 2 cycles after IDLE sample.
- io_req with base 0x0100, memory preloaded 0x0100..0x0103 = 1,2,3,4, BURST_LEN=4 -> io_ack on 4 consecutive cycles with data 1,2,3,4; io_done with the 4th ack; mem_we stays 0.
- Wrap: base 0xFFFE -> mem_addr sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Simultaneous cpu_req and io_req twice in a row:
  - without macro -> CPU, then CPU;
  - with macro -> CPU, then IO.
- cpu_req raised in the 2nd cycle of a burst -> burst completes undisturbed; cpu_ack exactly 2 cycles after the IDLE that follows io_done.
- reset asserted in the 3rd cycle of IO_BURST -> next cycle all outputs 0 and state IDLE; no io_done; a fresh io_req restarts at beat 0.
